// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the sprite RAM slave state type.
// Latency: none (constants, types and pure functions only).
// Backpressure: not applicable.
package ahb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HSIZE_BYTE = 3'b000;
   localparam logic [2:0] HSIZE_HALF = 3'b001;
   localparam logic [2:0] HSIZE_WORD = 3'b010;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR,
      ST_RD_ISSUE,
      ST_RD_DATA,
      ST_ERR1,
      ST_ERR2
   } slv_state_t;

   // Byte lanes touched by a transfer of the given size at byte offset a.
   function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] a);
      logic [3:0] m;
      case (size)
         HSIZE_BYTE: m = 4'b0001 << a;
         HSIZE_HALF: m = a[1] ? 4'b1100 : 4'b0011;
         default:    m = 4'b1111;
      endcase
      return m;
   endfunction

   // Oversized or misaligned transfers are answered with ERROR.
   function automatic logic xfer_err(input logic [2:0] size, input logic [1:0] a);
      return (size > HSIZE_WORD) ||
             ((size == HSIZE_HALF) && a[0]) ||
             ((size == HSIZE_WORD) && (a != 2'b00));
   endfunction

endpackage

// File: rtl/sprite_ram_sp.sv
// Single-port synchronous sprite RAM, 32-bit words with per-byte write enables.
// Latency: write commits at the clock edge; read data is registered, valid the next cycle.
// Backpressure: none; one access per cycle, a write cycle leaves the read register unchanged.
module sprite_ram_sp #(
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  i_clk,
   input  logic                  i_en,
   input  logic [3:0]            i_we,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   input  logic [31:0]           i_wdata,
   output logic [31:0]           o_rdata
);

   logic [31:0] r_mem [2**ADDR_WIDTH];
   logic [31:0] r_rdata;

   // Byte-lane write or registered read; no reset so this maps onto block RAM.
   always_ff @(posedge i_clk) begin
      if (i_en) begin
         for (int b = 0; b < 4; b++) begin
            if (i_we[b]) begin
               r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
            end
         end
         if (i_we == 4'b0000) begin
            r_rdata <= r_mem[i_addr];
         end
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/ahblite_sprite_ram.sv
// AHB-Lite slave over a sprite RAM shared with a video read port (request/grant).
// Latency: writes zero wait states, reads one wait state; video data one cycle after grant.
// Backpressure: HREADYOUT low while the bus loses the RAM, at most STARVE_LIMIT extra cycles.
module ahblite_sprite_ram
   import ahb_pkg::*;
#(
   parameter int ADDR_WIDTH   = 8,
   parameter int STARVE_LIMIT = 2
) (
   input  logic                  HCLK,
   input  logic                  HRESETn,
   input  logic                  HSEL,
   input  logic [31:0]           HADDR,
   input  logic [1:0]            HTRANS,
   input  logic [2:0]            HSIZE,
   input  logic                  HWRITE,
   input  logic [31:0]           HWDATA,
   input  logic                  HREADY,
   output logic                  HREADYOUT,
   output logic [31:0]           HRDATA,
   output logic                  HRESP,
   input  logic                  vid_req,
   input  logic [ADDR_WIDTH-1:0] vid_addr,
   output logic                  vid_gnt,
   output logic                  vid_rvalid,
   output logic [31:0]           vid_rdata
);

   localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE_LIMIT);

   slv_state_t            r_state;
   slv_state_t            w_state_nxt;
   slv_state_t            w_cap_state;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic                  r_write;
   logic [2:0]            r_size;
   logic [3:0]            r_mask;
   logic [CW-1:0]         r_starve;
   logic [31:0]           r_hrdata_hold;
   logic                  r_vid_rvalid;
   logic [31:0]           r_vid_hold;

   logic                  w_accept;
   logic                  w_err;
   logic                  w_take;
   logic                  w_bus_need;
   logic                  w_bus_win;
   logic                  w_vid_gnt;
   logic                  w_hreadyout;
   logic                  w_hresp;
   logic                  w_ram_en;
   logic [3:0]            w_ram_we;
   logic [ADDR_WIDTH-1:0] w_ram_addr;
   logic [ADDR_WIDTH-1:0] w_haddr_word;
   logic [31:0]           w_ram_q;
   logic                  w_unused;

   assign w_haddr_word = HADDR[ADDR_WIDTH+1:2];
   assign w_accept     = HSEL & HREADY & HTRANS[1];
   assign w_err        = xfer_err(HSIZE, HADDR[1:0]);
   assign w_cap_state  = w_err ? ST_ERR1 : (HWRITE ? ST_WR : ST_RD_ISSUE);

   // Video wins by default; the bus takes the RAM once it has lost STARVE_LIMIT times in a row.
   assign w_bus_need = (r_state == ST_WR) || (r_state == ST_RD_ISSUE);
   assign w_bus_win  = w_bus_need & (~vid_req | (r_starve == STARVE_MAX));
   assign w_vid_gnt  = HRESETn & vid_req & ~w_bus_win;

   // State register.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state, bus response and RAM port steering.
   always_comb begin
      w_state_nxt = r_state;
      w_hreadyout = 1'b1;
      w_hresp     = HRESP_OKAY;
      w_ram_en    = 1'b0;
      w_ram_we    = 4'b0000;
      w_ram_addr  = r_addr;
      w_take      = 1'b0;
      case (r_state)
         ST_IDLE: begin
         end
         ST_WR: begin
            w_hreadyout = w_bus_win;
            if (w_bus_win) begin
               w_ram_en = 1'b1;
               w_ram_we = r_mask;
            end
         end
         ST_RD_ISSUE: begin
            w_hreadyout = 1'b0;
            if (w_bus_win) begin
               w_ram_en    = 1'b1;
               w_state_nxt = ST_RD_DATA;
            end
         end
         ST_RD_DATA: begin
         end
         ST_ERR1: begin
            w_hreadyout = 1'b0;
            w_hresp     = HRESP_ERROR;
            w_state_nxt = ST_ERR2;
         end
         ST_ERR2: begin
            w_hresp = HRESP_ERROR;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
      // A completing data phase either chains into the next address phase or idles.
      if (w_hreadyout) begin
         w_take      = w_accept;
         w_state_nxt = w_accept ? w_cap_state : ST_IDLE;
      end
      if (w_vid_gnt) begin
         w_ram_en   = 1'b1;
         w_ram_addr = vid_addr;
      end
   end

   // Capture the address phase of every accepted transfer.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_addr  <= '0;
         r_write <= 1'b0;
         r_size  <= 3'b000;
         r_mask  <= 4'b0000;
      end else if (w_take) begin
         r_addr  <= w_haddr_word;
         r_write <= HWRITE;
         r_size  <= HSIZE;
         r_mask  <= lane_mask(HSIZE, HADDR[1:0]);
      end
   end

   // Consecutive bus losses, saturating at STARVE_LIMIT and cleared on a win.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_starve <= '0;
      end else if (w_bus_win) begin
         r_starve <= '0;
      end else if (w_bus_need && (r_starve != STARVE_MAX)) begin
         r_starve <= r_starve + 1'b1;
      end
   end

   // Hold registers keep both read ports stable once their data cycle has passed.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_hrdata_hold <= 32'h0;
         r_vid_rvalid  <= 1'b0;
         r_vid_hold    <= 32'h0;
      end else begin
         r_vid_rvalid <= w_vid_gnt;
         if (r_state == ST_RD_DATA) begin
            r_hrdata_hold <= w_ram_q;
         end
         if (r_vid_rvalid) begin
            r_vid_hold <= w_ram_q;
         end
      end
   end

   sprite_ram_sp #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ram (
      .i_clk   (HCLK),
      .i_en    (w_ram_en),
      .i_we    (w_ram_we),
      .i_addr  (w_ram_addr),
      .i_wdata (HWDATA),
      .o_rdata (w_ram_q)
   );

   assign HREADYOUT  = w_hreadyout;
   assign HRESP      = w_hresp;
   assign HRDATA     = (r_state == ST_RD_DATA) ? w_ram_q : r_hrdata_hold;
   assign vid_gnt    = w_vid_gnt;
   assign vid_rvalid = r_vid_rvalid;
   assign vid_rdata  = r_vid_rvalid ? w_ram_q : r_vid_hold;

   // Upper address bits, HTRANS[0] and the captured size/direction carry no further logic.
   assign w_unused = ^{1'b0, HADDR[31:ADDR_WIDTH+2], HTRANS[0], r_write, r_size};

endmodule

// File: tb/tb_ahblite_sprite_ram.sv
// Self-checking bench for ahblite_sprite_ram: transaction-level model plus directed tests.
// Latency: model checks every clock; directed results are taken at each data-phase completion.
// Backpressure: the bench master holds its address phase until HREADY is sampled high.
module tb_ahblite_sprite_ram;
   import ahb_pkg::*;

   localparam int AW = 8;
   localparam int SL = 2;
   localparam int K_NONE = 0, K_WR = 1, K_RD = 2, K_ERR = 3;

   logic          HCLK = 1'b0;
   logic          HRESETn = 1'b0;
   logic          HSEL = 1'b0;
   logic [31:0]   HADDR = 32'h0;
   logic [1:0]    HTRANS = 2'b00;
   logic [2:0]    HSIZE = 3'b010;
   logic          HWRITE = 1'b0;
   logic [31:0]   HWDATA = 32'h0;
   logic          HREADY;
   logic          HREADYOUT;
   logic [31:0]   HRDATA;
   logic          HRESP;
   logic          vid_req = 1'b0;
   logic [AW-1:0] vid_addr = '0;
   logic          vid_gnt;
   logic          vid_rvalid;
   logic [31:0]   vid_rdata;

   assign HREADY = HREADYOUT;

   ahblite_sprite_ram #(.ADDR_WIDTH(AW), .STARVE_LIMIT(SL)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
      .HSIZE(HSIZE), .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY),
      .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .HRESP(HRESP),
      .vid_req(vid_req), .vid_addr(vid_addr), .vid_gnt(vid_gnt),
      .vid_rvalid(vid_rvalid), .vid_rdata(vid_rdata)
   );

   always #5 HCLK = ~HCLK;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- transaction-level reference model ----------------
   logic [31:0] m_mem [256];
   int          m_kind = K_NONE;
   int          m_cyc = 0;
   bit          m_won = 1'b0;
   int          m_losses = 0;
   logic [7:0]  m_addr = 8'h0;
   logic [1:0]  m_lo = 2'b00;
   int          m_nb = 4;
   logic [31:0] m_rd_val = 32'h0;
   logic [31:0] m_hold = 32'h0;
   bit          m_vgnt_d = 1'b0;
   logic [31:0] m_vdata = 32'h0;
   logic [31:0] m_vhold = 32'h0;

   bit          e_need, e_win, e_gnt, e_ready, e_resp;
   logic [31:0] e_hrdata, e_vrdata;

   initial begin
      forever begin
         @(negedge HCLK);
         if (HRESETn) begin
            e_need = (m_kind == K_WR) || (m_kind == K_RD && !m_won);
            e_win  = e_need && (!vid_req || m_losses >= SL);
            e_gnt  = vid_req && !e_win;
            case (m_kind)
               K_NONE:  e_ready = 1'b1;
               K_WR:    e_ready = e_win;
               K_RD:    e_ready = m_won;
               default: e_ready = (m_cyc >= 1);
            endcase
            e_resp   = (m_kind == K_ERR);
            e_hrdata = (m_kind == K_RD && m_won) ? m_rd_val : m_hold;
            e_vrdata = m_vgnt_d ? m_vdata : m_vhold;
            chk("cyc_hreadyout", 32'(HREADYOUT), 32'(e_ready));
            chk("cyc_hresp", 32'(HRESP), 32'(e_resp));
            chk("cyc_hrdata", HRDATA, e_hrdata);
            chk("cyc_vid_gnt", 32'(vid_gnt), 32'(e_gnt));
            chk("cyc_vid_rvalid", 32'(vid_rvalid), 32'(m_vgnt_d));
            chk("cyc_vid_rdata", vid_rdata, e_vrdata);
         end
         @(posedge HCLK);
         if (!HRESETn) begin
            m_kind = K_NONE; m_cyc = 0; m_won = 1'b0; m_losses = 0;
            m_hold = 32'h0; m_vgnt_d = 1'b0; m_vhold = 32'h0;
         end else begin
            logic [31:0] w;
            logic [31:0] vnext;
            int          start;
            vnext = e_gnt ? m_mem[vid_addr] : m_vdata;
            if (m_kind == K_WR && e_win) begin
               w = m_mem[m_addr];
               start = int'(m_lo) & ~(m_nb - 1);
               for (int b = start; b < start + m_nb; b++) w[8*b +: 8] = HWDATA[8*b +: 8];
               m_mem[m_addr] = w;
            end
            if (m_kind == K_RD && e_need && e_win) begin
               m_won = 1'b1;
               m_rd_val = m_mem[m_addr];
            end
            if (e_need) m_losses = e_win ? 0 : m_losses + 1;
            m_vhold  = e_vrdata;
            m_vgnt_d = e_gnt;
            m_vdata  = vnext;
            m_hold   = e_hrdata;
            if (e_ready) begin
               if (HSEL && HTRANS[1]) begin
                  if (HSIZE > 3'd2 || (HSIZE == 3'd1 && HADDR[0]) || (HSIZE == 3'd2 && HADDR[1:0] != 2'b00))
                     m_kind = K_ERR;
                  else
                     m_kind = HWRITE ? K_WR : K_RD;
                  m_addr = HADDR[9:2];
                  m_lo   = HADDR[1:0];
                  m_nb   = (HSIZE <= 3'd2) ? (1 << HSIZE) : 4;
                  m_won  = 1'b0;
                  m_cyc  = 0;
               end else begin
                  m_kind = K_NONE;
               end
            end else begin
               m_cyc++;
            end
         end
      end
   end

   // ---------------- bus master ----------------
   typedef struct {
      logic [1:0]  trans;
      logic        wr;
      logic [2:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
   } item_t;

   item_t       seq_q[$];
   logic [31:0] res_rdata[$];
   logic        res_resp[$];
   logic        res_resp0[$];
   int          res_waits[$];

   task automatic push(input logic [1:0] t, input logic wr, input logic [2:0] s,
                       input logic [31:0] a, input logic [31:0] d);
      item_t it;
      it.trans = t; it.wr = wr; it.size = s; it.addr = a; it.wdata = d;
      seq_q.push_back(it);
   endtask

   // Pipelined master: address phase k overlaps data phase k-1; ends with one IDLE phase.
   task automatic run_seq();
      int   n;
      int   waits;
      logic r0;
      bit   first;
      n = seq_q.size();
      res_rdata.delete(); res_resp.delete(); res_resp0.delete(); res_waits.delete();
      for (int k = 0; k <= n; k++) begin
         HSEL = 1'b1;
         if (k < n) begin
            HTRANS = seq_q[k].trans; HWRITE = seq_q[k].wr;
            HSIZE = seq_q[k].size;   HADDR = seq_q[k].addr;
         end else begin
            HTRANS = HTRANS_IDLE; HWRITE = 1'b0; HSIZE = HSIZE_WORD; HADDR = 32'h0;
         end
         if (k > 0) HWDATA = seq_q[k-1].wdata;
         waits = 0; r0 = 1'b0; first = 1'b1;
         forever begin
            @(negedge HCLK);
            if (first) begin r0 = HRESP; first = 1'b0; end
            if (HREADY) break;
            waits++;
            if (waits > 40) begin
               checks++; failures++;
               $display("FAIL seq_timeout: waits %0d exceed bound 40", waits);
               break;
            end
         end
         if (k > 0) begin
            res_rdata.push_back(HRDATA); res_resp.push_back(HRESP);
            res_resp0.push_back(r0);     res_waits.push_back(waits);
         end
         @(posedge HCLK); #1;
      end
      seq_q.delete();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(posedge HCLK);
      #1;
      chk("rst_hreadyout", 32'(HREADYOUT), 32'h1);
      chk("rst_hresp", 32'(HRESP), 32'h0);
      chk("rst_hrdata", HRDATA, 32'h0);
      chk("rst_vid_gnt", 32'(vid_gnt), 32'h0);
      chk("rst_vid_rvalid", 32'(vid_rvalid), 32'h0);
      chk("rst_vid_rdata", vid_rdata, 32'h0);
      HRESETn = 1'b1;
      HSEL = 1'b1;

      // Word write then read, no video traffic.
      push(HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h10, 32'hDEADBEEF);
      push(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h10, 32'h0);
      run_seq();
      chk("t1_wr_waits", 32'(res_waits[0]), 32'd0);
      chk("t1_rd_waits", 32'(res_waits[1]), 32'd1);
      chk("t1_rd_data", res_rdata[1], 32'hDEADBEEF);
      chk("t1_rd_resp", 32'(res_resp[1]), 32'h0);

      // Byte lanes.
      push(HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h20, 32'h11223344);
      push(HTRANS_NONSEQ, 1'b1, HSIZE_BYTE, 32'h22, 32'h00AA0000);
      push(HTRANS_NONSEQ, 1'b1, HSIZE_HALF, 32'h20, 32'h0000BBCC);
      push(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h20, 32'h0);
      run_seq();
      chk("t2_byte_waits", 32'(res_waits[1]), 32'd0);
      chk("t2_half_waits", 32'(res_waits[2]), 32'd0);
      chk("t2_rd_data", res_rdata[3], 32'h11AABBCC);

      // Error responses with video requesting; the following read is accepted in ERR2.
      vid_req = 1'b1; vid_addr = 8'd4;
      push(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h21, 32'h0);
      push(HTRANS_NONSEQ, 1'b0, 3'd3, 32'h20, 32'h0);
      push(HTRANS_SEQ, 1'b0, HSIZE_HALF, 32'h23, 32'h0);
      push(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h20, 32'h0);
      run_seq();
      vid_req = 1'b0;
      chk("t3_mis_waits", 32'(res_waits[0]), 32'd1);
      chk("t3_mis_resp1", 32'(res_resp0[0]), 32'h1);
      chk("t3_mis_resp2", 32'(res_resp[0]), 32'h1);
      chk("t3_size3_waits", 32'(res_waits[1]), 32'd1);
      chk("t3_size3_resp1", 32'(res_resp0[1]), 32'h1);
      chk("t3_size3_resp2", 32'(res_resp[1]), 32'h1);
      chk("t3_half_resp", 32'(res_resp[2]), 32'h1);
      chk("t3_after_err_data", res_rdata[3], 32'h11AABBCC);
      chk("t3_after_err_resp", 32'(res_resp[3]), 32'h0);

      // Starvation: bus loses twice, wins on the third cycle.
      vid_req = 1'b1; vid_addr = 8'd8;
      push(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h10, 32'h0);
      run_seq();
      vid_req = 1'b0;
      chk("t4_starve_waits", 32'(res_waits[0]), 32'd3);
      chk("t4_starve_data", res_rdata[0], 32'hDEADBEEF);

      // Back-to-back write/read of one word, then IDLE (upper address bits ignored).
      push(HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h4000_0004, 32'hCAFEF00D);
      push(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h04, 32'h0);
      run_seq();
      chk("t5_wr_waits", 32'(res_waits[0]), 32'd0);
      chk("t5_rd_waits", 32'(res_waits[1]), 32'd1);
      chk("t5_rd_data", res_rdata[1], 32'hCAFEF00D);
      @(negedge HCLK);
      chk("t5_idle_ready", 32'(HREADYOUT), 32'h1);
      @(posedge HCLK); #1;

      // Reset while a read is stalled in RD_ISSUE.
      vid_req = 1'b1; vid_addr = 8'd8;
      HTRANS = HTRANS_NONSEQ; HWRITE = 1'b0; HSIZE = HSIZE_WORD; HADDR = 32'h10;
      @(posedge HCLK); #1;
      HTRANS = HTRANS_IDLE;
      chk("t6_issue_stall", 32'(HREADYOUT), 32'h0);
      #1 HRESETn = 1'b0;
      #1;
      chk("t6_rst_hreadyout", 32'(HREADYOUT), 32'h1);
      chk("t6_rst_hresp", 32'(HRESP), 32'h0);
      chk("t6_rst_hrdata", HRDATA, 32'h0);
      chk("t6_rst_vid_gnt", 32'(vid_gnt), 32'h0);
      chk("t6_rst_vid_rvalid", 32'(vid_rvalid), 32'h0);
      chk("t6_rst_vid_rdata", vid_rdata, 32'h0);
      @(posedge HCLK); #1;
      vid_req = 1'b0;
      HRESETn = 1'b1;
      push(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h10, 32'h0);
      push(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h04, 32'h0);
      run_seq();
      chk("t6_fresh_waits", 32'(res_waits[0]), 32'd1);
      chk("t6_fresh_data", res_rdata[0], 32'hDEADBEEF);
      chk("t6_second_data", res_rdata[1], 32'hCAFEF00D);

      repeat (3) @(posedge HCLK);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ahblite_sprite_ram.md
# ahblite_sprite_ram

AHB-Lite slave that exposes a word-organised sprite/attribute RAM on one peripheral port of the system AHB interconnect, and shares that RAM with the video engine through a second request/grant read port. It is the responder side of the interconnect's peripheral interface. It generates wait states, byte-lane writes and the two-cycle AHB ERROR response. It arbitrates a single-port synchronous RAM between the bus and the video engine, with starvation protection for the bus.

## Interface
- `ADDR_WIDTH`, default 8: RAM word-address bits (256 words = 1 KiB window).
- `STARVE_LIMIT`, default 2: consecutive cycles the bus may lose arbitration before it wins.
- `HCLK` in 1: system clock.
- `HRESETn` in 1: reset. One clock; reset is asynchronous and active-low.
- `HSEL` in 1: slave select from the interconnect decoder.
- `HADDR` in 32: byte address; only bits [ADDR_WIDTH+1:0] are used, upper bits are ignored.
- `HTRANS` in 2: transfer type.
- `HSIZE` in 3: transfer size.
- `HWRITE` in 1: 1 = write.
- `HWDATA` in 32: write data, valid in the data phase.
- `HREADY` in 1: bus-wide ready from the interconnect.
- `HREADYOUT` out 1: this slave's ready.
- `HRDATA` out 32: read data.
- `HRESP` out 1: 0 = OKAY, 1 = ERROR.
- `vid_req` in 1: video read request.
- `vid_addr` in ADDR_WIDTH: video word address.
- `vid_gnt` out 1: request granted this cycle.
- `vid_rvalid` out 1: `vid_rdata` valid, one cycle after `vid_gnt`.
- `vid_rdata` out 32: video read data.

## Operation
- **Address-phase capture.** An address phase is accepted when `HSEL & HREADY & HTRANS[1]`. On acceptance the block registers the word address, `HWRITE`, `HSIZE` and the byte-lane mask:
  - byte: lane `HADDR[1:0]`;
  - halfword: lanes {`HADDR[1]`*2, +1};
  - word: all lanes.
- **IDLE and BUSY transfers**, or an unselected slave: no state change, `HREADYOUT=1`, `HRESP=0`.
- **Error detection**, checked at capture. A transfer is in error if any of these holds:
  - `HSIZE>2`;
  - a halfword with `HADDR[0]=1`;
  - a word with `HADDR[1:0]!=0`.
  - An erroneous transfer goes to ERR1 and the RAM is never accessed.
- **State machine** (states IDLE, WR, RD_ISSUE, RD_DATA, ERR1, ERR2):
  - IDLE → WR, RD_ISSUE or ERR1 on an accepted transfer.
  - WR: RAM is written with `HWDATA` under the lane mask in the first cycle the bus wins arbitration. `HREADYOUT=1` in that cycle, 0 while losing. Then → IDLE, or directly to the next captured transfer.
  - RD_ISSUE: `HREADYOUT=0`. The RAM read is issued when the bus wins, then → RD_DATA.
  - RD_DATA: `HREADYOUT=1`, `HRDATA` = RAM word, then → IDLE or the next captured transfer.
  - ERR1: `HREADYOUT=0`, `HRESP=1`, then → ERR2.
  - ERR2: `HREADYOUT=1`, `HRESP=1`, then → IDLE or the next captured transfer. An address phase presented in ERR2 is accepted normally.
- **Arbitration**, evaluated each cycle the bus needs the RAM (WR or RD_ISSUE):
  - By default `vid_req` wins and `vid_gnt=1`.
  - A saturating counter counts consecutive bus losses. When it equals `STARVE_LIMIT`, the bus wins and `vid_gnt=0` even if `vid_req=1`.
  - The counter clears whenever the bus wins.
  - When the bus does not need the RAM, `vid_gnt=vid_req`.

## Timing
- **Reset values:** `HREADYOUT=1`, `HRESP=0`, `HRDATA=0`, `vid_gnt=0`, `vid_rvalid=0`, `vid_rdata=0`, state IDLE, starvation counter 0. RAM contents are undefined.
- **Write latency:** zero wait states without contention; the data phase completes in the first data-phase cycle.
- **Read latency:** exactly one wait state without contention (one cycle `HREADYOUT=0`, then data).
- **Worst case under continuous `vid_req`:** STARVE_LIMIT extra wait cycles.
- **Video port:** `vid_rvalid` and `vid_rdata` are registered and arrive exactly one cycle after `vid_gnt`. `vid_gnt` is combinational from `vid_req` and the bus state.
- **Read output hold:** `HRDATA` holds its last read value outside RD_DATA and is never X after reset.
- **Reset mid-operation:** all state is abandoned immediately and a pending write is discarded. `HREADYOUT` returns to 1 asynchronously.
- **Read-after-write:** a bus read immediately following a write to the same word returns the new data. The write commits to RAM before RD_ISSUE can win the RAM.

## Structure
- A shared package `ahb_pkg` holds:
  - the HTRANS encodings (IDLE/BUSY/NONSEQ/SEQ);
  - the HSIZE byte/half/word codes;
  - the HRESP OKAY/ERROR constants;
  - the slave FSM state enum.
- Sub-module `sprite_ram_sp`: single-port synchronous RAM with 4 byte-write enables and a registered read. It is parameterised by ADDR_WIDTH and is the natural FPGA BRAM inference point.

## Test plan
- **Word write then read, no video:** write 0xDEADBEEF to 0x10, then read 0x10.
  - Write completes with 0 waits.
  - Read gets 1 wait, then `HRDATA=0xDEADBEEF`, `HRESP=0`.
- **Byte lanes:** word 0x11223344 at 0x20, then byte write 0xAA at 0x22, then halfword write 0xBBCC at 0x20. Read 0x20 → 0x11AABBCC.
- **Misaligned word read at 0x21:**
  - Cycle 1: `HREADYOUT=0`, `HRESP=1`.
  - Cycle 2: `HREADYOUT=1`, `HRESP=1`.
  - RAM is not accessed and `vid_gnt` is unaffected.
  - `HSIZE=3` at 0x20 gives the same response.
- **Starvation:** `vid_req` held high, then a bus read issued.
  - Bus loses 2 cycles (`vid_gnt=1`), wins the 3rd (`vid_gnt=0`).
  - `HRDATA` is valid in the 4th data-phase cycle.
  - Each grant yields `vid_rvalid` one cycle later with the correct data.
- **Back-to-back pipelined transfers:** NONSEQ write 0x04 / NONSEQ read 0x04 / IDLE.
  - Read returns the just-written value.
  - IDLE phase: `HREADYOUT=1`, no RAM access.
- **Reset mid-read:** assert `HRESETn` low while in RD_ISSUE.
  - All outputs go to their reset values in the same cycle.
  - After release, a fresh read completes normally.
